// File: rtl/dds_sweep_pkg.sv
// Shared types and constants for the DDS frequency sweep sequencer.
// Register offsets are word indices taken from paddr[4:2].
package dds_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } state_e;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_SAW    = 2'd1;
   localparam logic [1:0] MODE_TRI    = 2'd2;

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_START  = 3'd1;
   localparam logic [2:0] OFF_STOP   = 3'd2;
   localparam logic [2:0] OFF_INC    = 3'd3;
   localparam logic [2:0] OFF_DWELL  = 3'd4;
   localparam logic [2:0] OFF_STATUS = 3'd5;
   localparam logic [2:0] OFF_CUR    = 3'd6;

   localparam int CTRL_GO      = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_MODE_LO = 2;
   localparam int CTRL_MODE_HI = 3;
   localparam int CTRL_TRIG_EN = 4;

   // A programmed dwell of 0 behaves as a dwell of 1.
   function automatic logic [31:0] dwell_m1(input logic [31:0] d);
      return (d == 32'd0) ? 32'd0 : d - 32'd1;
   endfunction

endpackage

// File: rtl/dds_sweep_if.sv
// APB slave bundle for the sweep sequencer; prdata is the only slave-driven signal.
interface dds_sweep_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata
   );
endinterface

// File: rtl/dds_sweep_regs.sv
// APB register file: START/STOP/INC/DWELL/CTRL storage, GO/ABORT strobes, read mux.
// Writes land at the access edge; GO/ABORT are single-cycle strobes seen that same cycle.
module dds_sweep_regs
   import dds_sweep_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   dds_sweep_if.slave  apb,
   input  logic [2:0]  status,
   input  logic [31:0] cur,
   output logic        go,
   output logic        abort,
   output logic [1:0]  mode,
   output logic        trig_en,
   output logic [31:0] start,
   output logic [31:0] stop,
   output logic [31:0] inc,
   output logic [31:0] dwell
);

   logic [1:0]  mode_q,    mode_d;
   logic        trig_en_q, trig_en_d;
   logic [31:0] start_q,   start_d;
   logic [31:0] stop_q,    stop_d;
   logic [31:0] inc_q,     inc_d;
   logic [31:0] dwell_q,   dwell_d;
   logic [31:0] rdata;
   logic [2:0]  off;
   logic        wr;
   logic        ctrl_wr;
   logic        unused_addr;

   assign off         = apb.paddr[4:2];
   assign wr          = apb.psel & apb.penable & apb.pwrite;
   assign ctrl_wr     = wr && (off == OFF_CTRL);
   assign unused_addr = ^{apb.paddr[31:5], apb.paddr[1:0]};

   assign go    = ctrl_wr & apb.pwdata[CTRL_GO];
   assign abort = ctrl_wr & apb.pwdata[CTRL_ABORT];

   always_comb begin
      mode_d    = mode_q;
      trig_en_d = trig_en_q;
      start_d   = start_q;
      stop_d    = stop_q;
      inc_d     = inc_q;
      dwell_d   = dwell_q;
      if (wr) begin
         case (off)
            OFF_CTRL: begin
               mode_d    = apb.pwdata[CTRL_MODE_HI:CTRL_MODE_LO];
               trig_en_d = apb.pwdata[CTRL_TRIG_EN];
            end
            OFF_START: start_d = apb.pwdata;
            OFF_STOP:  stop_d  = apb.pwdata;
            OFF_INC:   inc_d   = apb.pwdata;
            OFF_DWELL: dwell_d = apb.pwdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q    <= 2'd0;
         trig_en_q <= 1'b0;
         start_q   <= 32'd0;
         stop_q    <= 32'd0;
         inc_q     <= 32'd0;
         dwell_q   <= 32'd1;
      end else begin
         mode_q    <= mode_d;
         trig_en_q <= trig_en_d;
         start_q   <= start_d;
         stop_q    <= stop_d;
         inc_q     <= inc_d;
         dwell_q   <= dwell_d;
      end
   end

   // MODE/TRIG_EN are forwarded as next-state so a GO sees the fields written alongside it.
   assign mode    = mode_d;
   assign trig_en = trig_en_d;
   assign start   = start_q;
   assign stop    = stop_q;
   assign inc     = inc_q;
   assign dwell   = dwell_q;

   always_comb begin
      rdata = 32'd0;
      if (apb.psel) begin
         case (off)
            OFF_CTRL:   rdata = {27'd0, trig_en_q, mode_q, 2'b00};
            OFF_START:  rdata = start_q;
            OFF_STOP:   rdata = stop_q;
            OFF_INC:    rdata = inc_q;
            OFF_DWELL:  rdata = dwell_q;
            OFF_STATUS: rdata = {29'd0, status};
            OFF_CUR:    rdata = cur;
            default:    rdata = 32'd0;
         endcase
      end
   end

   assign apb.prdata = rdata;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS step sweep sequencer: single/sawtooth/triangle ramp with per-value dwell.
// GO or trig produces step=START on the next cycle; each value is held max(DWELL,1) cycles.
module dds_sweep_ctrl
   import dds_sweep_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   dds_sweep_if.slave  apb,
   input  logic        trig,
   output logic [31:0] step,
   output logic        active,
   output logic        done
);

   logic        go, abort, reg_trig_en;
   logic [1:0]  reg_mode;
   logic [31:0] reg_start, reg_stop, reg_inc, reg_dwell;

   state_e      state_q,   state_d;
   logic [31:0] step_q,    step_d;
   logic [31:0] cnt_q,     cnt_d;
   logic [31:0] w_start_q, w_start_d;
   logic [31:0] w_stop_q,  w_stop_d;
   logic [31:0] w_inc_q,   w_inc_d;
   logic [31:0] w_dwm1_q,  w_dwm1_d;
   logic [1:0]  w_mode_q,  w_mode_d;
   logic        active_q,  active_d;
   logic        done_q,    done_d;
   logic        sticky_q,  sticky_d;

   logic [32:0] up_sum, dn_diff;
   logic [31:0] up_val, dn_val;

   dds_sweep_regs u_regs (
      .clk     (clk),
      .reset   (reset),
      .apb     (apb),
      .status  ({state_q == ARMED, sticky_q, active_q}),
      .cur     (step_q),
      .go      (go),
      .abort   (abort),
      .mode    (reg_mode),
      .trig_en (reg_trig_en),
      .start   (reg_start),
      .stop    (reg_stop),
      .inc     (reg_inc),
      .dwell   (reg_dwell)
   );

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      w_start_d = w_start_q;
      w_stop_d  = w_stop_q;
      w_inc_d   = w_inc_q;
      w_dwm1_d  = w_dwm1_q;
      w_mode_d  = w_mode_q;
      sticky_d  = sticky_q;
      done_d    = 1'b0;

      up_sum  = {1'b0, step_q} + {1'b0, w_inc_q};
      dn_diff = {1'b0, step_q} - {1'b0, w_inc_q};
      up_val  = (up_sum >= {1'b0, w_stop_q}) ? w_stop_q : up_sum[31:0];
      dn_val  = (dn_diff[32] || (dn_diff[31:0] <= w_start_q)) ? w_start_q : dn_diff[31:0];

      if (abort) begin
         state_d = IDLE;
      end else if (go) begin
         // Ceiling is max(START,STOP) so START>=STOP degenerates into holding START.
         w_start_d = reg_start;
         w_stop_d  = (reg_start >= reg_stop) ? reg_start : reg_stop;
         w_inc_d   = reg_inc;
         w_dwm1_d  = dwell_m1(reg_dwell);
         w_mode_d  = reg_mode;
         sticky_d  = 1'b0;
         if (reg_trig_en) begin
            state_d = ARMED;
         end else begin
            state_d = UP;
            step_d  = reg_start;
            cnt_d   = dwell_m1(reg_dwell);
         end
      end else begin
         case (state_q)
            ARMED: begin
               if (trig) begin
                  state_d = UP;
                  step_d  = w_start_q;
                  cnt_d   = w_dwm1_q;
               end
            end
            UP: begin
               if (cnt_q != 32'd0) begin
                  cnt_d = cnt_q - 32'd1;
               end else begin
                  cnt_d = w_dwm1_q;
                  if (step_q >= w_stop_q) begin
                     case (w_mode_q)
                        MODE_SAW: step_d = w_start_q;
                        MODE_TRI: begin
                           state_d = DOWN;
                           step_d  = dn_val;
                        end
                        default: begin
                           state_d  = IDLE;
                           done_d   = 1'b1;
                           sticky_d = 1'b1;
                        end
                     endcase
                  end else begin
                     step_d = up_val;
                  end
               end
            end
            DOWN: begin
               if (cnt_q != 32'd0) begin
                  cnt_d = cnt_q - 32'd1;
               end else begin
                  cnt_d = w_dwm1_q;
                  if (step_q <= w_start_q) begin
                     state_d = UP;
                     step_d  = up_val;
                  end else begin
                     step_d = dn_val;
                  end
               end
            end
            default: ;
         endcase
      end

      active_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         step_q    <= 32'd0;
         cnt_q     <= 32'd0;
         w_start_q <= 32'd0;
         w_stop_q  <= 32'd0;
         w_inc_q   <= 32'd0;
         w_dwm1_q  <= 32'd0;
         w_mode_q  <= MODE_SINGLE;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cnt_q     <= cnt_d;
         w_start_q <= w_start_d;
         w_stop_q  <= w_stop_d;
         w_inc_q   <= w_inc_d;
         w_dwm1_q  <= w_dwm1_d;
         w_mode_q  <= w_mode_d;
         active_q  <= active_d;
         done_q    <= done_d;
         sticky_q  <= sticky_d;
      end
   end

   assign step   = step_q;
   assign active = active_q;
   assign done   = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a value-list sweep model checked every cycle, plus literal traces.
module tb_dds_sweep_ctrl;

   typedef struct packed {
      logic [31:0] step;
      logic        active;
      logic        done;
   } exp_t;

   localparam int CAP = 400;

   logic        clk;
   logic        reset;
   logic        trig;
   logic [31:0] step;
   logic        active;
   logic        done;

   dds_sweep_if apb_if ();

   dds_sweep_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .apb    (apb_if),
      .trig   (trig),
      .step   (step),
      .active (active),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   exp_t        exp_q[$];
   exp_t        cur;
   logic [31:0] trace[$];

   // shadow of what the bench has programmed
   longint m_start, m_stop, m_inc, m_dwell;
   int     m_mode;
   bit     m_trig_en;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic push_exp(input longint v, input bit a, input bit d);
      exp_t e;
      e.step   = v[31:0];
      e.active = a;
      e.done   = d;
      exp_q.push_back(e);
   endtask

   // Expected per-cycle outputs of a sweep that starts on the next cycle.
   task automatic model_start();
      longint s, p, i, v;
      int     d, md;
      longint up[$];
      longint cyc[$];
      s  = m_start;
      p  = m_stop;
      i  = m_inc;
      d  = (m_dwell == 0) ? 1 : int'(m_dwell);
      md = (m_mode == 3) ? 0 : m_mode;
      exp_q.delete();
      if (s >= p) begin
         if (md == 0) begin
            for (int k = 0; k < d; k++) push_exp(s, 1'b1, 1'b0);
            push_exp(s, 1'b0, 1'b1);
         end else begin
            for (int k = 0; k < CAP; k++) push_exp(s, 1'b1, 1'b0);
         end
         return;
      end
      if (i == 0) begin
         for (int k = 0; k < CAP; k++) push_exp(s, 1'b1, 1'b0);
         return;
      end
      v = s;
      up.push_back(v);
      while (v < p) begin
         v = (v + i >= p) ? p : v + i;
         up.push_back(v);
      end
      if (md == 0) begin
         foreach (up[j]) for (int k = 0; k < d; k++) push_exp(up[j], 1'b1, 1'b0);
         push_exp(p, 1'b0, 1'b1);
         return;
      end
      cyc = up;
      if (md == 2) begin
         v = p;
         while (v > s) begin
            v = (v - i <= s) ? s : v - i;
            if (v > s) cyc.push_back(v);
         end
      end
      for (int k = 0; k < CAP; k++) push_exp(cyc[(k / d) % cyc.size()], 1'b1, 1'b0);
   endtask

   // Runs between an active edge and the following falling edge.
   task automatic model_ctrl(input logic [31:0] data);
      m_mode    = int'(data[3:2]);
      m_trig_en = data[4];
      if (data[1]) begin
         exp_q.delete();
         cur.active = 1'b0;
         cur.done   = 1'b0;
      end else if (data[0]) begin
         if (m_trig_en) begin
            exp_q.delete();
            cur.active = 1'b1;
            cur.done   = 1'b0;
         end else begin
            model_start();
         end
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur.done = 1'b0;
      chk("cyc_step", step, cur.step);
      chk("cyc_active", {31'd0, active}, {31'd0, cur.active});
      chk("cyc_done", {31'd0, done}, {31'd0, cur.done});
      trace.push_back(step);
      if (done) done_cnt++;
   end

   // All bus tasks are entered and left 1 time unit after a rising edge.
   task automatic apb_write(input logic [2:0] off, input logic [31:0] data);
      apb_if.psel    = 1'b1;
      apb_if.penable = 1'b0;
      apb_if.pwrite  = 1'b1;
      apb_if.paddr   = {27'd0, off, 2'b00};
      apb_if.pwdata  = data;
      @(posedge clk); #1;
      apb_if.penable = 1'b1;
      @(posedge clk); #1;
      apb_if.psel    = 1'b0;
      apb_if.penable = 1'b0;
      apb_if.pwrite  = 1'b0;
      case (off)
         3'd0: model_ctrl(data);
         3'd1: m_start = longint'(data);
         3'd2: m_stop  = longint'(data);
         3'd3: m_inc   = longint'(data);
         3'd4: m_dwell = longint'(data);
         default: ;
      endcase
   endtask

   task automatic apb_read(input logic [2:0] off, output logic [31:0] data);
      apb_if.psel    = 1'b1;
      apb_if.penable = 1'b0;
      apb_if.pwrite  = 1'b0;
      apb_if.paddr   = {27'd0, off, 2'b00};
      @(posedge clk); #1;
      apb_if.penable = 1'b1;
      #1 data = apb_if.prdata;
      @(posedge clk); #1;
      apb_if.psel    = 1'b0;
      apb_if.penable = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] off, input logic [31:0] expv);
      logic [31:0] r;
      apb_read(off, r);
      chk(nm, r, expv);
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      @(posedge clk); #1;
      trig = 1'b0;
      model_start();
   endtask

   task automatic chk_trace(input string nm, input logic [31:0] expv[], input int n);
      for (int k = 0; k < n; k++) begin
         if (k < trace.size()) chk(nm, trace[k], expv[k]);
         else chk(nm, 32'hDEAD_BEEF, expv[k]);
      end
   endtask

   task automatic reset_regs();
      for (int k = 0; k < 8; k++) begin
         rd_chk("reset_reg", 3'(k), (k == 4) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      logic [31:0] t_single[] = '{32'd100, 32'd100, 32'd110, 32'd110, 32'd120,
                                  32'd120, 32'd130, 32'd130, 32'd130, 32'd130};
      logic [31:0] t_tri[]    = '{32'd0, 32'd8, 32'd16, 32'd20, 32'd12,
                                  32'd4, 32'd0, 32'd8, 32'd16, 32'd20};
      logic [31:0] t_clamp[]  = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] t_trig[]   = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd8};

      cur = '0;
      m_start = 0; m_stop = 0; m_inc = 0; m_dwell = 1; m_mode = 0; m_trig_en = 1'b0;
      reset = 1'b0;
      trig  = 1'b0;
      apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
      apb_if.paddr = 32'd0; apb_if.pwdata = 32'd0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // reset state
      chk("rst_step", step, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      reset_regs();
      chk("prdata_idle", apb_if.prdata, 32'd0);

      // single sweep
      apb_write(3'd1, 32'd100);
      apb_write(3'd2, 32'd130);
      apb_write(3'd3, 32'd10);
      apb_write(3'd4, 32'd2);
      apb_write(3'd0, 32'h1);
      trace.delete();
      repeat (12) @(posedge clk); #1;
      chk_trace("single_trace", t_single, 10);
      chk("single_done_cnt", done_cnt, 1);
      rd_chk("single_status", 3'd5, 32'h2);
      rd_chk("single_cur", 3'd6, 32'd130);

      // triangle
      apb_write(3'd1, 32'd0);
      apb_write(3'd2, 32'd20);
      apb_write(3'd3, 32'd8);
      apb_write(3'd4, 32'd1);
      apb_write(3'd0, 32'h9);
      trace.delete();
      repeat (12) @(posedge clk); #1;
      chk_trace("tri_trace", t_tri, 10);
      chk("tri_active", {31'd0, active}, 32'd1);
      apb_write(3'd0, 32'h2);
      repeat (2) @(posedge clk); #1;

      // clamp at the top of the 32-bit range
      apb_write(3'd1, 32'hFFFF_FFF0);
      apb_write(3'd2, 32'hFFFF_FFFF);
      apb_write(3'd3, 32'h10);
      apb_write(3'd0, 32'h1);
      trace.delete();
      repeat (6) @(posedge clk); #1;
      chk_trace("clamp_trace", t_clamp, 4);
      chk("clamp_done_cnt", done_cnt, 2);

      // triggered start
      apb_write(3'd1, 32'd5);
      apb_write(3'd2, 32'd8);
      apb_write(3'd3, 32'd1);
      apb_write(3'd0, 32'h11);
      rd_chk("armed_status", 3'd5, 32'h5);
      repeat (3) @(posedge clk); #1;
      chk("armed_step_hold", step, 32'hFFFF_FFFF);
      pulse_trig();
      trace.delete();
      repeat (7) @(posedge clk); #1;
      chk_trace("trig_trace", t_trig, 5);
      chk("trig_done_cnt", done_cnt, 3);
      rd_chk("trig_status", 3'd5, 32'h2);

      // abort mid-sawtooth, then GO+ABORT together
      apb_write(3'd1, 32'd0);
      apb_write(3'd2, 32'd1000);
      apb_write(3'd0, 32'h5);
      repeat (36) @(posedge clk); #1;
      apb_write(3'd0, 32'h2);
      repeat (3) @(posedge clk); #1;
      chk("abort_step", step, 32'd37);
      chk("abort_active", {31'd0, active}, 32'd0);
      chk("abort_no_done", done_cnt, 3);
      apb_write(3'd0, 32'h3);
      repeat (3) @(posedge clk); #1;
      chk("goabort_active", {31'd0, active}, 32'd0);
      chk("goabort_step", step, 32'd37);
      rd_chk("goabort_status", 3'd5, 32'h0);

      // reset mid-sweep
      apb_write(3'd0, 32'h5);
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      exp_q.delete();
      cur = '0;
      m_start = 0; m_stop = 0; m_inc = 0; m_dwell = 1; m_mode = 0; m_trig_en = 1'b0;
      #1;
      chk("midrst_step", step, 32'd0);
      chk("midrst_active", {31'd0, active}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      reset_regs();
      repeat (2) @(posedge clk); #1;
      chk("midrst_no_done", done_cnt, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
